// File: rtl/regfile_spi_reader.sv
// regfile_spi_reader
//
// SPI slave (mode 0) debug port that streams CPU register-file contents out
// to an external host. The host sends an 8-bit read command `1_00_aaaaa`
// and then clocks out 32-bit words starting at register `aaaaa`. The address
// auto-increments (mod 32) for as long as chip select stays low. SCLK, CS and
// MOSI are oversampled in the core clock domain.
//
// Ports:
//   clk           core clock, all state updates on posedge
//   rst           asynchronous, active-low reset
//   spi_sclk      SPI clock from host (CPOL=0, CPHA=0), asynchronous
//   spi_cs_n      chip select, active-low, asynchronous
//   spi_mosi      host-to-slave data, MSB first
//   spi_miso      slave-to-host data, MSB first, 0 when not shifting
//   dbg_reg_addr  read address to the register file debug port
//   dbg_reg_data  combinational read data for dbg_reg_addr
//   busy          high whenever a frame is in progress
//   word_done     one-clk pulse after each fully shifted 32-bit word
//   frame_err     one-clk pulse on a bad command or an aborted frame
module regfile_spi_reader (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [4:0]  dbg_reg_addr,
    input  logic [31:0] dbg_reg_data,
    output logic        busy,
    output logic        word_done,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LOAD,
        S_DATA,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    // Bits [1:0] form the 2-FF synchronizer, bit [2] is the previous
    // synchronized sample used for edge detection.
    logic [2:0]  sclk_sync_q, sclk_sync_d;
    logic [2:0]  cs_sync_q, cs_sync_d;
    logic [1:0]  mosi_sync_q, mosi_sync_d;
    // Counts the clocks after reset until the synchronizer holds real pin
    // values rather than its reset levels.
    logic [1:0]  fill_q, fill_d;
    // Set once CS has been seen high from the pin; a CS that was already low
    // when reset ended must not look like a frame start.
    logic        armed_q, armed_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [31:0] shift_q, shift_d;
    logic [4:0]  addr_q, addr_d;
    logic        miso_q, miso_d;
    logic        word_done_q, word_done_d;
    logic        frame_err_q, frame_err_d;

    logic        sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic [7:0]  cmd_shifted;
    logic        cmd_valid;

    assign sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_fall     = armed_q & cs_sync_q[2] & ~cs_sync_q[1];
    assign cs_rise     = cs_sync_q[1] & ~cs_sync_q[2];
    assign cmd_shifted = {cmd_q[6:0], mosi_sync_q[1]};
    assign cmd_valid   = cmd_shifted[7] & (cmd_shifted[6:5] == 2'b00);

    always_comb begin
        state_d     = state_q;
        sclk_sync_d = {sclk_sync_q[1:0], spi_sclk};
        cs_sync_d   = {cs_sync_q[1:0], spi_cs_n};
        mosi_sync_d = {mosi_sync_q[0], spi_mosi};
        fill_d      = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
        armed_d     = armed_q | ((fill_q == 2'd2) & cs_sync_q[1]);
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        miso_d      = miso_q;
        word_done_d = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                miso_d = 1'b0;
                cnt_d  = 5'd0;
                if (cs_fall) begin
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (sclk_rise) begin
                    cmd_d = cmd_shifted;
                    if (cnt_q == 5'd7) begin
                        cnt_d = 5'd0;
                        if (cmd_valid) begin
                            addr_d  = cmd_shifted[4:0];
                            state_d = S_LOAD;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_ERR;
                        end
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            S_LOAD: begin
                // Snapshot: later register writes do not affect this word.
                shift_d = dbg_reg_data;
                cnt_d   = 5'd0;
                state_d = S_DATA;
            end
            S_DATA: begin
                if (sclk_fall) begin
                    miso_d  = shift_q[31];
                    shift_d = {shift_q[30:0], 1'b0};
                end
                if (sclk_rise) begin
                    if (cnt_q == 5'd31) begin
                        cnt_d       = 5'd0;
                        word_done_d = 1'b1;
                        addr_d      = addr_q + 5'd1;
                        state_d     = S_LOAD;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            S_ERR: begin
                miso_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // CS rise ends the frame from any state; only a rise in the middle
        // of a command byte or data word counts as an abort.
        if (cs_rise) begin
            state_d = S_IDLE;
            miso_d  = 1'b0;
            cnt_d   = 5'd0;
            if (((state_q == S_CMD) || (state_q == S_DATA)) && (cnt_q != 5'd0)) begin
                frame_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            sclk_sync_q <= 3'b000;
            cs_sync_q   <= 3'b111;
            mosi_sync_q <= 2'b00;
            fill_q      <= 2'd0;
            armed_q     <= 1'b0;
            cnt_q       <= 5'd0;
            cmd_q       <= 8'd0;
            shift_q     <= 32'd0;
            addr_q      <= 5'd0;
            miso_q      <= 1'b0;
            word_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            fill_q      <= fill_d;
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            miso_q      <= miso_d;
            word_done_q <= word_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign spi_miso     = miso_q;
    assign dbg_reg_addr = addr_q;
    assign busy         = (state_q != S_IDLE);
    assign word_done    = word_done_q;
    assign frame_err    = frame_err_q;

endmodule
